fft_output_reorder: RTL and testbench

//  Consumes the sample stream of the final SdfUnit stage of the radix-2^2 SDF FFT pipeline.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/reorder_ram.sv | 40 ++++
 rtl/fft_output_reorder.sv | 147 ++++++++++++++
 tb/tb_fft_output_reorder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, types and helper functions for the FFT output reorder block.
// Functions here are used both for elaboration-time sizing and for address generation.
package fft_pkg;

    localparam int FFT_WIDTH = 16;
    localparam int MAX_LOG   = 16;

    typedef struct packed {
        logic [FFT_WIDTH-1:0] re;
        logic [FFT_WIDTH-1:0] im;
    } cplx_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Reverses the low 'bits' bits of v into the low bits of the result; upper bits stay zero.
    function automatic logic [MAX_LOG-1:0] bitrev(input logic [MAX_LOG-1:0] v, input int bits);
        logic [MAX_LOG-1:0] r;
        logic [MAX_LOG-1:0] s;
        r = '0;
        s = v;
        for (int i = 0; i < MAX_LOG; i++) begin
            if (i < bits) begin
                r = {r[MAX_LOG-2:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port frame buffer: synchronous write on port A, registered read on port B.
// The address MSB selects the ping-pong bank.
module reorder_ram
    import fft_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int DW    = 32,
    parameter int AW    = 7
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Storage is deliberately not reset; stale contents are never emitted.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_output_reorder.sv
// Reorders bit-reversed FFT frames into natural bin order using a ping-pong buffer.
// Optional feature: define FFT_REORDER_ERR_EN to add the err abort-pulse output.
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int N     = 64,
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_last
`ifdef FFT_REORDER_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int LOG_N = log2(N);
    localparam int AW    = LOG_N + 1;
    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

    typedef enum logic {
        RD_IDLE,
        RD_ACTIVE
    } rd_state_t;

    logic [LOG_N-1:0] wr_count_q, wr_count_d;
    logic             wr_bank_q, wr_bank_d;
    rd_state_t        rd_state_q, rd_state_d;
    logic [LOG_N-1:0] rd_count_q, rd_count_d;
    logic             rd_bank_q, rd_bank_d;
    logic             do_en_q, do_en_d;
    logic             do_last_q, do_last_d;
    logic             arm;
    logic             rd_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [2*WIDTH-1:0] rd_data;

    assign wr_addr = {wr_bank_q, LOG_N'(bitrev(MAX_LOG'(wr_count_q), LOG_N))};
    assign rd_addr = {rd_bank_q, rd_count_q};
    assign rd_en   = (rd_state_q == RD_ACTIVE);

    // Write side: count samples, complete or discard the frame, arm the read of a full bank.
    always_comb begin
        wr_count_d = wr_count_q;
        wr_bank_d  = wr_bank_q;
        arm        = 1'b0;
        if (di_en) begin
            if (wr_count_q == LAST) begin
                wr_count_d = '0;
                wr_bank_d  = ~wr_bank_q;
                arm        = 1'b1;
            end else begin
                wr_count_d = wr_count_q + 1'b1;
            end
        end else if (wr_count_q != '0) begin
            wr_count_d = '0;
        end
    end

    // A new arm can only coincide with the final read of the previous frame, so it simply restarts.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_count_d = rd_count_q;
        rd_bank_d  = rd_bank_q;
        do_en_d    = (rd_state_q == RD_ACTIVE);
        do_last_d  = (rd_state_q == RD_ACTIVE) && (rd_count_q == LAST);
        if (arm) begin
            rd_state_d = RD_ACTIVE;
            rd_count_d = '0;
            rd_bank_d  = wr_bank_q;
        end else if (rd_state_q == RD_ACTIVE) begin
            if (rd_count_q == LAST) begin
                rd_state_d = RD_IDLE;
            end
            rd_count_d = rd_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_count_q <= '0;
            wr_bank_q  <= 1'b0;
            rd_state_q <= RD_IDLE;
            rd_count_q <= '0;
            rd_bank_q  <= 1'b0;
            do_en_q    <= 1'b0;
            do_last_q  <= 1'b0;
        end else begin
            wr_count_q <= wr_count_d;
            wr_bank_q  <= wr_bank_d;
            rd_state_q <= rd_state_d;
            rd_count_q <= rd_count_d;
            rd_bank_q  <= rd_bank_d;
            do_en_q    <= do_en_d;
            do_last_q  <= do_last_d;
        end
    end

    reorder_ram #(
        .DEPTH (2 * N),
        .DW    (2 * WIDTH),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (di_en),
        .wr_addr (wr_addr),
        .wr_data ({di_re, di_im}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign do_en   = do_en_q;
    assign do_last = do_last_q;
    assign do_re   = rd_data[2*WIDTH-1:WIDTH];
    assign do_im   = rd_data[WIDTH-1:0];

`ifdef FFT_REORDER_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = 1'b0;
        if (!di_en && (wr_count_q != '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_fft_output_reorder.sv
// Self-checking bench for fft_output_reorder: random frames against a bit-reversal reference model.
// Also exercises an N=4 instance; honours FFT_REORDER_ERR_EN for the err output.
module tb_fft_output_reorder;
    import fft_pkg::*;

    localparam int N     = 64;
    localparam int LOG_N = 6;
    localparam int LAT   = N + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        di_en = 1'b0;
    logic [15:0] di_re = '0;
    logic [15:0] di_im = '0;
    logic        do_en;
    logic [15:0] do_re;
    logic [15:0] do_im;
    logic        do_last;

    logic        s_en = 1'b0;
    logic [15:0] s_re = '0;
    logic [15:0] s_im = '0;
    logic        s_do_en;
    logic [15:0] s_do_re;
    logic [15:0] s_do_im;
    logic        s_do_last;
`ifdef FFT_REORDER_ERR_EN
    logic        err;
    logic        s_err;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    fft_output_reorder #(.N(N), .WIDTH(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .di_en   (di_en),
        .di_re   (di_re),
        .di_im   (di_im),
        .do_en   (do_en),
        .do_re   (do_re),
        .do_im   (do_im),
        .do_last (do_last)
`ifdef FFT_REORDER_ERR_EN
        , .err   (err)
`endif
    );

    fft_output_reorder #(.N(4), .WIDTH(16)) dut4 (
        .clock   (clock),
        .reset   (reset),
        .di_en   (s_en),
        .di_re   (s_re),
        .di_im   (s_im),
        .do_en   (s_do_en),
        .do_re   (s_do_re),
        .do_im   (s_do_im),
        .do_last (s_do_last)
`ifdef FFT_REORDER_ERR_EN
        , .err   (s_err)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int brev(input int x, input int bits);
        int r;
        int v;
        r = 0;
        v = x;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Reference model: collect whole frames, schedule natural-order output by cycle number.
    cplx_t cur[$];
    int    cur_start;
    cplx_t exp_out[int];
    bit    exp_last[int];
    bit    exp_err[int];

    always @(posedge clock) begin
        if (!reset) begin
            if (di_en) begin
                if (cur.size() == 0) cur_start = cyc;
                cur.push_back('{re: di_re, im: di_im});
                if (cur.size() == N) begin
                    for (int j = 0; j < N; j++) begin
                        exp_out[cur_start + LAT + j]  = cur[brev(j, LOG_N)];
                        exp_last[cur_start + LAT + j] = (j == N - 1);
                    end
                    cur.delete();
                end
            end else if (cur.size() != 0) begin
                cur.delete();
                exp_err[cyc + 1] = 1'b1;
            end
        end
    end

    // Output recorder, sampled mid-cycle.
    logic        obs_en[int];
    logic [15:0] obs_re[int];
    logic [15:0] obs_im[int];
    logic        obs_last[int];
`ifdef FFT_REORDER_ERR_EN
    logic        obs_err[int];
`endif

    always @(negedge clock) begin
        obs_en[cyc]   = do_en;
        obs_re[cyc]   = do_re;
        obs_im[cyc]   = do_im;
        obs_last[cyc] = do_last;
`ifdef FFT_REORDER_ERR_EN
        obs_err[cyc]  = err;
`endif
    end

    task automatic drive(input logic en, input logic [15:0] re, input logic [15:0] im);
        @(posedge clock);
        #1;
        di_en = en;
        di_re = re;
        di_im = im;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (do_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_do_en: got %b expected 0", do_en); end
        checks++;
        if (do_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_do_last: got %b expected 0", do_last); end
`ifdef FFT_REORDER_ERR_EN
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_ramp();
        int t0;
        int c;
        int b;
        t0 = 0;
        for (int k = 0; k < N; k++) begin
            drive(1'b1, 16'(k), 16'(-k));
            if (k == 0) t0 = cyc;
        end
        idle(N + 4);
        checks++;
        if (obs_en[t0 + LAT - 1] !== 1'b0) begin errors++; $display("[TB] FAIL ramp_en_early: got %b expected 0", obs_en[t0 + LAT - 1]); end
        for (int j = 0; j < N; j++) begin
            c = t0 + LAT + j;
            b = brev(j, LOG_N);
            checks++;
            if (obs_en[c] !== 1'b1 || obs_re[c] !== 16'(b) || obs_im[c] !== 16'(-b) || obs_last[c] !== (j == N - 1)) begin
                errors++;
                $display("[TB] FAIL ramp bin %0d: got en=%b re=%0d im=%0d last=%b expected en=1 re=%0d im=%0d last=%b",
                         j, obs_en[c], obs_re[c], $signed(obs_im[c]), obs_last[c], b, -b, (j == N - 1));
            end
        end
        checks++;
        if (obs_en[t0 + LAT + N] !== 1'b0) begin errors++; $display("[TB] FAIL ramp_en_late: got %b expected 0", obs_en[t0 + LAT + N]); end
    endtask

    task automatic test_impulse();
        int t0;
        int c;
        t0 = 0;
        for (int k = 0; k < N; k++) begin
            drive(1'b1, (k == 1) ? 16'd1000 : 16'd0, 16'd0);
            if (k == 0) t0 = cyc;
        end
        idle(N + 4);
        for (int j = 0; j < N; j++) begin
            c = t0 + LAT + j;
            checks++;
            if (obs_en[c] !== 1'b1 || obs_re[c] !== ((j == 32) ? 16'd1000 : 16'd0) || obs_im[c] !== 16'd0 || obs_last[c] !== (j == N - 1)) begin
                errors++;
                $display("[TB] FAIL impulse bin %0d: got en=%b re=%0d im=%0d last=%b expected en=1 re=%0d im=0 last=%b",
                         j, obs_en[c], obs_re[c], obs_im[c], obs_last[c], (j == 32) ? 1000 : 0, (j == N - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int c;
        int er;
        t0 = 0;
        for (int k = 0; k < 4 * N; k++) begin
            drive(1'b1, 16'(k), 16'($urandom));
            if (k == 0) t0 = cyc;
        end
        idle(N + 4);
        checks++;
        if (obs_en[t0 + LAT - 1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_en_early: got %b expected 0", obs_en[t0 + LAT - 1]); end
        for (int i = 0; i < 4 * N; i++) begin
            c  = t0 + LAT + i;
            er = N * (i / N) + brev(i % N, LOG_N);
            checks++;
            if (!exp_out.exists(c) || obs_en[c] !== 1'b1 || obs_re[c] !== 16'(er) || obs_im[c] !== exp_out[c].im
                || obs_last[c] !== ((i % N) == N - 1)) begin
                errors++;
                $display("[TB] FAIL b2b out %0d: got en=%b re=%0d im=%h last=%b expected en=1 re=%0d last=%b",
                         i, obs_en[c], obs_re[c], obs_im[c], obs_last[c], er, ((i % N) == N - 1));
            end
        end
        checks++;
        if (obs_en[t0 + LAT + 4 * N] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_en_late: got %b expected 0", obs_en[t0 + LAT + 4 * N]); end
    endtask

    task automatic test_abort();
        int ws;
        int en_cnt;
        bit ee;
        ws = cyc + 1;
        en_cnt = 0;
        for (int k = 0; k < 20; k++) drive(1'b1, 16'($urandom), 16'($urandom));
        idle(3);
        for (int k = 0; k < N; k++) drive(1'b1, 16'($urandom), 16'($urandom));
        idle(N + 4);
        for (int c = ws; c < cyc; c++) begin
            ee = exp_out.exists(c);
            if (obs_en[c] === 1'b1) en_cnt++;
            checks++;
            if (obs_en[c] !== ee) begin errors++; $display("[TB] FAIL abort_en cyc %0d: got %b expected %b", c, obs_en[c], ee); end
            if (ee) begin
                checks++;
                if (obs_re[c] !== exp_out[c].re || obs_im[c] !== exp_out[c].im || obs_last[c] !== exp_last[c]) begin
                    errors++;
                    $display("[TB] FAIL abort_data cyc %0d: got re=%h im=%h last=%b expected re=%h im=%h last=%b",
                             c, obs_re[c], obs_im[c], obs_last[c], exp_out[c].re, exp_out[c].im, exp_last[c]);
                end
            end
`ifdef FFT_REORDER_ERR_EN
            checks++;
            if (obs_err[c] !== exp_err.exists(c)) begin errors++; $display("[TB] FAIL abort_err cyc %0d: got %b expected %b", c, obs_err[c], exp_err.exists(c)); end
`endif
        end
        checks++;
        if (en_cnt != N) begin errors++; $display("[TB] FAIL abort_frame_len: got %0d enabled cycles expected %0d", en_cnt, N); end
    endtask

    task automatic test_random();
        int ws;
        int n;
        bit ee;
        ws = cyc + 1;
        for (int f = 0; f < 6; f++) begin
            idle(int'($urandom_range(0, 2)));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : N;
            for (int k = 0; k < n; k++) drive(1'b1, 16'($urandom), 16'($urandom));
            if (n < N) idle(1);
        end
        idle(N + 4);
        for (int c = ws; c < cyc; c++) begin
            ee = exp_out.exists(c);
            checks++;
            if (obs_en[c] !== ee) begin errors++; $display("[TB] FAIL random_en cyc %0d: got %b expected %b", c, obs_en[c], ee); end
            if (ee) begin
                checks++;
                if (obs_re[c] !== exp_out[c].re || obs_im[c] !== exp_out[c].im || obs_last[c] !== exp_last[c]) begin
                    errors++;
                    $display("[TB] FAIL random_data cyc %0d: got re=%h im=%h last=%b expected re=%h im=%h last=%b",
                             c, obs_re[c], obs_im[c], obs_last[c], exp_out[c].re, exp_out[c].im, exp_last[c]);
                end
            end
`ifdef FFT_REORDER_ERR_EN
            checks++;
            if (obs_err[c] !== exp_err.exists(c)) begin errors++; $display("[TB] FAIL random_err cyc %0d: got %b expected %b", c, obs_err[c], exp_err.exists(c)); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        int ws;
        int keys[$];
        bit ee;
        t0 = 0;
        for (int k = 0; k < N; k++) begin
            drive(1'b1, 16'($urandom), 16'($urandom));
            if (k == 0) t0 = cyc;
        end
        while (cyc < t0 + LAT + 30) drive(1'b0, 16'($urandom), 16'($urandom));
        #1;
        checks++;
        if (do_en !== 1'b1 || !exp_out.exists(cyc) || do_re !== exp_out[cyc].re) begin
            errors++;
            $display("[TB] FAIL reset_mid_bin30: got en=%b re=%h before reset", do_en, do_re);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (do_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_do_en: got %b expected 0", do_en); end
        checks++;
        if (do_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_do_last: got %b expected 0", do_last); end
        cur.delete();
        foreach (exp_out[k]) if (k >= cyc) keys.push_back(k);
        foreach (keys[i]) begin
            exp_out.delete(keys[i]);
            exp_last.delete(keys[i]);
        end
        ws = cyc;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);
        for (int k = 0; k < N; k++) drive(1'b1, 16'($urandom), 16'($urandom));
        idle(N + 4);
        for (int c = ws; c < cyc; c++) begin
            ee = exp_out.exists(c);
            checks++;
            if (obs_en[c] !== ee) begin errors++; $display("[TB] FAIL reset_mid_en cyc %0d: got %b expected %b", c, obs_en[c], ee); end
            if (ee) begin
                checks++;
                if (obs_re[c] !== exp_out[c].re || obs_im[c] !== exp_out[c].im || obs_last[c] !== exp_last[c]) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_data cyc %0d: got re=%h im=%h last=%b expected re=%h im=%h last=%b",
                             c, obs_re[c], obs_im[c], obs_last[c], exp_out[c].re, exp_out[c].im, exp_last[c]);
                end
            end
        end
    endtask

    task automatic test_small_n();
        logic [15:0] vals[4];
        int t0;
        int c;
        int j;
        bit ee;
        t0 = 0;
        for (int k = 0; k < 4; k++) vals[k] = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            s_en = 1'b1;
            s_re = vals[k];
            s_im = ~vals[k];
            if (k == 0) t0 = cyc;
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            s_en = 1'b0;
            @(negedge clock);
            c  = cyc;
            ee = (c >= t0 + 5) && (c <= t0 + 8);
            checks++;
            if (s_do_en !== ee) begin errors++; $display("[TB] FAIL n4_en cyc +%0d: got %b expected %b", c - t0, s_do_en, ee); end
            if (ee) begin
                j = c - t0 - 5;
                checks++;
                if (s_do_re !== vals[brev(j, 2)] || s_do_im !== ~vals[brev(j, 2)] || s_do_last !== (j == 3)) begin
                    errors++;
                    $display("[TB] FAIL n4_bin %0d: got re=%h im=%h last=%b expected re=%h im=%h last=%b",
                             j, s_do_re, s_do_im, s_do_last, vals[brev(j, 2)], ~vals[brev(j, 2)], (j == 3));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_impulse();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_mid();
        test_small_n();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
